maxpool_ctrl: RTL and testbench

Sequencer that wraps the 2x2/stride-2 max-pool datapath for one 6x6 feature-map frame of 16-bit values.
- Accepts a frame as a raster-order valid/ready pixel stream into an internal 36-entry buffer.
- Computes the nine window maxima one per cycle.
- Streams the 3x3 result out over a valid/ready interface with a last flag.
- Sits between the conv output stage and the next layer or writeback DMA.

---
 rtl/maxpool_pkg.sv | 25 ++
 rtl/maxpool_ctrl_if.sv | 22 ++
 rtl/maxpool_ctrl_max4_cmp.sv | 31 +++
 rtl/maxpool_ctrl.sv | 127 ++++++++++++
 tb/tb_maxpool_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/maxpool_pkg.sv
// Shared sizing, FSM state type and window-address helper for the 2x2/stride-2 max-pool sequencer.
package maxpool_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned IN_DIM    = 6;
  localparam int unsigned OUT_DIM   = IN_DIM / 2;
  localparam int unsigned IN_CNT_W  = $clog2(IN_DIM * IN_DIM);
  localparam int unsigned OUT_CNT_W = $clog2(OUT_DIM * OUT_DIM);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } state_t;

  // Buffer address of the top-left pixel of output window idx (raster order over the pooled map).
  function automatic logic [IN_CNT_W-1:0] win_base(input logic [OUT_CNT_W-1:0] idx);
    int unsigned i;
    int unsigned j;
    i = 32'(idx) / OUT_DIM;
    j = 32'(idx) % OUT_DIM;
    return IN_CNT_W'(2 * i * IN_DIM + 2 * j);
  endfunction

endpackage

// File: rtl/maxpool_ctrl_if.sv
// Pixel-in / result-out valid-ready streams of the max-pool sequencer.
interface maxpool_ctrl_if;
  import maxpool_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/maxpool_ctrl_max4_cmp.sv
// Combinational 4-input maximum; MAXPOOL_SIGNED_EN selects two's-complement instead of unsigned compare.
module max4_cmp
  import maxpool_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] result
);

  function automatic logic gt(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef MAXPOOL_SIGNED_EN
    return $signed(x) > $signed(y);
`else
    return x > y;
`endif
  endfunction

  logic [WIDTH-1:0] ab;
  logic [WIDTH-1:0] cd;

  always_comb begin
    ab     = gt(b, a) ? b : a;
    cd     = gt(d, c) ? d : c;
    result = gt(cd, ab) ? cd : ab;
  end

endmodule

// File: rtl/maxpool_ctrl.sv
// Max-pool sequencer: buffers one IN_DIMxIN_DIM frame, then streams the OUT_DIMxOUT_DIM window maxima.
module maxpool_ctrl
  import maxpool_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  maxpool_ctrl_if.slave       bus
);

  localparam logic [IN_CNT_W-1:0]  LAST_IN  = IN_CNT_W'(IN_DIM * IN_DIM - 1);
  localparam logic [OUT_CNT_W-1:0] LAST_OUT = OUT_CNT_W'(OUT_DIM * OUT_DIM - 1);
  localparam logic [IN_CNT_W-1:0]  ROW_STEP = IN_CNT_W'(IN_DIM);

  state_t              state;
  logic [IN_CNT_W-1:0] wr_idx;
  logic [OUT_CNT_W-1:0] out_idx;
  logic [OUT_CNT_W-1:0] sel;
  logic [IN_CNT_W-1:0] base;
  logic [IN_CNT_W-1:0] addr1;
  logic [IN_CNT_W-1:0] addr2;
  logic [IN_CNT_W-1:0] addr3;
  logic [DATA_W-1:0]   win_max;
  logic [DATA_W-1:0]   pix_buf [IN_DIM*IN_DIM];
  logic                in_hs;
  logic                out_hs;

  assign in_hs  = (state == LOAD) && bus.in_valid && bus.in_ready && !abort;
  assign out_hs = (state == EMIT) && bus.out_valid && bus.out_ready && !abort;

  always_ff @(posedge clk) begin
    if (in_hs) pix_buf[wr_idx] <= bus.in_data;
  end

  // Comparator looks one window ahead so the next maximum is ready at each output handshake;
  // outside EMIT it points at window 0, which is captured on the final input accept.
  always_comb begin
    sel = '0;
    if (state == EMIT && out_idx != LAST_OUT) sel = out_idx + 1'b1;
    base  = win_base(sel);
    addr1 = base + 1'b1;
    addr2 = base + ROW_STEP;
    addr3 = base + ROW_STEP + 1'b1;
  end

  max4_cmp #(.WIDTH(DATA_W)) u_max4 (
    .a      (pix_buf[base]),
    .b      (pix_buf[addr1]),
    .c      (pix_buf[addr2]),
    .d      (pix_buf[addr3]),
    .result (win_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_idx        <= '0;
      out_idx       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            busy         <= 1'b1;
            bus.in_ready <= 1'b1;
            wr_idx       <= '0;
            out_idx      <= '0;
          end
        end
        LOAD, EMIT: begin
          if (abort) begin
            state         <= IDLE;
            wr_idx        <= '0;
            out_idx       <= '0;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
          end else if (in_hs) begin
            if (wr_idx == LAST_IN) begin
              state         <= EMIT;
              wr_idx        <= '0;
              out_idx       <= '0;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.out_last  <= (LAST_OUT == '0);
              bus.out_data  <= win_max;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end else if (out_hs) begin
            if (out_idx == LAST_OUT) begin
              state         <= IDLE;
              out_idx       <= '0;
              busy          <= 1'b0;
              done          <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              out_idx      <= out_idx + 1'b1;
              bus.out_data <= win_max;
              bus.out_last <= ((out_idx + 1'b1) == LAST_OUT);
            end
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Randomized bench for maxpool_ctrl against a frame-level pooling model.
module tb_maxpool_ctrl;
  import maxpool_pkg::*;

  localparam int unsigned NPIX = IN_DIM * IN_DIM;
  localparam int unsigned NOUT = OUT_DIM * OUT_DIM;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  maxpool_ctrl_if bus();

  maxpool_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [DATA_W-1:0] frame [NPIX];
  logic [DATA_W-1:0] expq  [NOUT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic bit bigger(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
`ifdef MAXPOOL_SIGNED_EN
    return $signed(x) > $signed(y);
`else
    return x > y;
`endif
  endfunction

  // Fold every pixel into the output cell it pools into.
  task automatic build_model();
    bit seen [NOUT];
    for (int unsigned o = 0; o < NOUT; o++) seen[o] = 1'b0;
    for (int unsigned p = 0; p < NPIX; p++) begin
      int unsigned r, c, o;
      r = p / IN_DIM;
      c = p % IN_DIM;
      o = (r / 2) * OUT_DIM + (c / 2);
      if (!seen[o] || bigger(frame[p], expq[o])) begin
        expq[o] = frame[p];
        seen[o] = 1'b1;
      end
    end
  endtask

  task automatic fill_ramp();
    for (int unsigned p = 0; p < NPIX; p++) frame[p] = DATA_W'(p);
    build_model();
  endtask

  task automatic fill_random();
    for (int unsigned p = 0; p < NPIX; p++) frame[p] = DATA_W'($urandom);
    build_model();
  endtask

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic load_frame(input int unsigned count, input int unsigned gap_pct, input bit start_noise);
    int unsigned n   = 0;
    int unsigned cyc = 0;
    while (n < count && cyc < 4000) begin
      bit v;
      v = ($urandom_range(99) >= gap_pct);
      bus.in_valid = v;
      bus.in_data  = v ? frame[n] : DATA_W'($urandom);
      start        = start_noise && ($urandom_range(3) == 0);
      check("out_valid_in_load", bus.out_valid, 0);
      if (v && bus.in_ready) n++;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    check("load_count", n, count);
  endtask

  task automatic drain_frame(input int unsigned mode, input int unsigned stop_at, input bit start_noise);
    int unsigned k   = 0;
    int unsigned cyc = 0;
    bit tog = 1'b1;
    check("first_valid_latency", bus.out_valid, 1);
    while (k < stop_at && cyc < 4000) begin
      bit r;
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = !tog; end
        default: r = 1'($urandom_range(1));
      endcase
      bus.out_ready = r;
      start = start_noise && (k < NOUT - 1) && ($urandom_range(3) == 0);
      check("out_valid", bus.out_valid, 1);
      check($sformatf("out_data[%0d]", k), bus.out_data, expq[k]);
      check($sformatf("out_last[%0d]", k), bus.out_last, (k == NOUT - 1));
      check("in_ready_in_emit", bus.in_ready, 0);
      if (bus.out_valid && r) k++;
      @(negedge clk);
      cyc++;
    end
    start         = 1'b0;
    bus.out_ready = 1'b0;
    check("drain_count", k, stop_at);
    if (stop_at == NOUT) begin
      check("done_pulse", done, 1);
      check("out_valid_drop", bus.out_valid, 0);
      check("out_last_drop", bus.out_last, 0);
      check("busy_end", busy, 0);
      @(negedge clk);
      check("done_single", done, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", bus.out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 0);

    // Ramp frame, continuous flow.
    fill_ramp();
    start_frame();
    load_frame(NPIX, 0, 1'b0);
    drain_frame(0, NOUT, 1'b0);

    // Ramp frame with input gaps and 1010 backpressure.
    fill_ramp();
    start_frame();
    load_frame(NPIX, 30, 1'b0);
    drain_frame(1, NOUT, 1'b0);

    // Signedness probe in window 0.
    fill_random();
    frame[0] = 16'h0001;
    frame[1] = 16'hFFFF;
    frame[IN_DIM]     = 16'h0002;
    frame[IN_DIM + 1] = 16'h0003;
    build_model();
    start_frame();
    load_frame(NPIX, 20, 1'b0);
`ifdef MAXPOOL_SIGNED_EN
    check("window0_signed", bus.out_data, 32'h0003);
`else
    check("window0_unsigned", bus.out_data, 32'hFFFF);
`endif
    drain_frame(2, NOUT, 1'b0);

    // Stray start pulses during LOAD/EMIT, then back-to-back frame after done.
    fill_random();
    start_frame();
    load_frame(NPIX, 20, 1'b1);
    drain_frame(2, NOUT, 1'b1);
    fill_random();
    start_frame();
    load_frame(NPIX, 10, 1'b0);
    drain_frame(2, NOUT, 1'b0);

    // Abort in LOAD after 20 pixels, with a competing input beat.
    fill_random();
    start_frame();
    load_frame(20, 0, 1'b0);
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'($urandom);
    @(negedge clk);
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_load_busy", busy, 0);
    check("abort_load_in_ready", bus.in_ready, 0);
    check("abort_load_done", done, 0);
    @(negedge clk);
    check("abort_load_stays_idle", busy, 0);
    fill_ramp();
    start_frame();
    load_frame(NPIX, 0, 1'b0);
    drain_frame(0, NOUT, 1'b0);

    // Abort in EMIT with a competing output handshake.
    fill_random();
    start_frame();
    load_frame(NPIX, 0, 1'b0);
    drain_frame(0, 3, 1'b0);
    abort         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    abort         = 1'b0;
    bus.out_ready = 1'b0;
    check("abort_emit_out_valid", bus.out_valid, 0);
    check("abort_emit_out_last", bus.out_last, 0);
    check("abort_emit_done", done, 0);
    check("abort_emit_busy", busy, 0);
    fill_random();
    start_frame();
    load_frame(NPIX, 15, 1'b0);
    drain_frame(2, NOUT, 1'b0);

    // Asynchronous reset mid-EMIT at out_idx 4.
    fill_random();
    start_frame();
    load_frame(NPIX, 0, 1'b0);
    drain_frame(0, 4, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_out_data", bus.out_data, 0);
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_out_last", bus.out_last, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    fill_random();
    start_frame();
    load_frame(NPIX, 25, 1'b0);
    drain_frame(2, NOUT, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
